// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester round-robin arbiter and sequencer in front of the
//            single-port 256-byte data RAM. One request is granted at a time,
//            the RAM command is driven for exactly one cycle, and a one-cycle
//            response pulse is returned to the granted requester.
// Revision : 1.0 - initial release
//
// Parameters
//   ADDR_W  byte-address width (matches RAM address)
//   DATA_W  data width
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_a_* / o_a_*         port A (core load/store unit)
//                         valid/ready request handshake, we, funct3, addr,
//                         wdata; rsp_valid pulse with rdata
//   i_b_* / o_b_*         port B (debug/DMA loader), same set as port A
//   o_mem_wren            RAM write enable (ACCESS cycle only)
//   o_mem_funct3          RAM access size
//   o_mem_address         RAM byte address
//   o_mem_data            RAM write data
//   i_mem_rdata           RAM combinational read data
//
// Build option
//   DMEM_ARB_LOAD_EXT_EN  when defined, load responses are sign/zero-extended
//                         according to the latched funct3 (RV32 semantics);
//                         otherwise the raw captured RAM word is returned.
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic              i_a_we,
    input  logic [2:0]        i_a_funct3,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_rsp_valid,
    output logic [DATA_W-1:0] o_a_rdata,

    input  logic              i_b_valid,
    output logic              o_b_ready,
    input  logic              i_b_we,
    input  logic [2:0]        i_b_funct3,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_b_rsp_valid,
    output logic [DATA_W-1:0] o_b_rdata,

    output logic              o_mem_wren,
    output logic [2:0]        o_mem_funct3,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_ACCESS = c_ST_ACCESS,
        ST_RESP   = c_ST_RESP
    } state_t;

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

    state_t              r_state_q,      w_state_d;
    logic                r_last_grant_q, w_last_grant_d;
    logic                r_cmd_we_q,     w_cmd_we_d;
    logic [2:0]          r_cmd_funct3_q, w_cmd_funct3_d;
    logic [ADDR_W-1:0]   r_cmd_addr_q,   w_cmd_addr_d;
    logic [DATA_W-1:0]   r_cmd_wdata_q,  w_cmd_wdata_d;
    logic                r_cmd_id_q,     w_cmd_id_d;
    logic [DATA_W-1:0]   r_a_rdata_q,    w_a_rdata_d;
    logic [DATA_W-1:0]   r_b_rdata_q,    w_b_rdata_d;

    logic                w_can_accept;
    logic                w_grant_a;
    logic                w_grant_b;
    logic                w_accept;
    logic                w_store_en;
    logic [DATA_W-1:0]   w_load_data;
    logic [DATA_W-1:0]   w_rsp_data;

    // ------------------------------------------------------------------
    // Arbitration. Ready is held low while reset is asserted so no request
    // appears accepted during reset. On a tie the port that did not win
    // last time is granted.
    // ------------------------------------------------------------------
    always_comb begin
        w_can_accept = i_rst && ((r_state_q == ST_IDLE) || (r_state_q == ST_RESP));
        w_grant_a    = w_can_accept && i_a_valid &&
                       (!i_b_valid || (r_last_grant_q == c_PORT_B));
        w_grant_b    = w_can_accept && i_b_valid &&
                       (!i_a_valid || (r_last_grant_q == c_PORT_A));
        w_accept     = w_grant_a || w_grant_b;
    end

    // Sizes other than byte/half/word are acknowledged but never written.
    always_comb begin
        w_store_en = r_cmd_we_q &&
                     ((r_cmd_funct3_q == 3'b000) ||
                      (r_cmd_funct3_q == 3'b001) ||
                      (r_cmd_funct3_q == 3'b010));
    end

    // Load data formatting applied while capturing the RAM word.
    always_comb begin
        w_load_data = i_mem_rdata;
`ifdef DMEM_ARB_LOAD_EXT_EN
        case (r_cmd_funct3_q)
            3'b000:  w_load_data = {{(DATA_W-8){i_mem_rdata[7]}},   i_mem_rdata[7:0]};
            3'b001:  w_load_data = {{(DATA_W-16){i_mem_rdata[15]}}, i_mem_rdata[15:0]};
            3'b100:  w_load_data = {{(DATA_W-8){1'b0}},             i_mem_rdata[7:0]};
            3'b101:  w_load_data = {{(DATA_W-16){1'b0}},            i_mem_rdata[15:0]};
            default: w_load_data = i_mem_rdata;
        endcase
`endif
        w_rsp_data = r_cmd_we_q ? '0 : w_load_data;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_cmd_we_d     = r_cmd_we_q;
        w_cmd_funct3_d = r_cmd_funct3_q;
        w_cmd_addr_d   = r_cmd_addr_q;
        w_cmd_wdata_d  = r_cmd_wdata_q;
        w_cmd_id_d     = r_cmd_id_q;
        w_a_rdata_d    = r_a_rdata_q;
        w_b_rdata_d    = r_b_rdata_q;

        case (r_state_q)
            ST_IDLE, ST_RESP: begin
                w_state_d = w_accept ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                w_state_d = ST_RESP;
                // Each port has its own rdata register so a port's last
                // response stays visible while the other port is served.
                if (r_cmd_id_q == c_PORT_A) begin
                    w_a_rdata_d = w_rsp_data;
                end else begin
                    w_b_rdata_d = w_rsp_data;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_last_grant_d = w_grant_b ? c_PORT_B : c_PORT_A;
            w_cmd_id_d     = w_grant_b ? c_PORT_B : c_PORT_A;
            w_cmd_we_d     = w_grant_b ? i_b_we     : i_a_we;
            w_cmd_funct3_d = w_grant_b ? i_b_funct3 : i_a_funct3;
            w_cmd_addr_d   = w_grant_b ? i_b_addr   : i_a_addr;
            w_cmd_wdata_d  = w_grant_b ? i_b_wdata  : i_a_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: RAM command only in ACCESS, response pulse only in RESP.
    // ------------------------------------------------------------------
    always_comb begin
        o_a_ready     = w_grant_a;
        o_b_ready     = w_grant_b;
        o_a_rsp_valid = 1'b0;
        o_b_rsp_valid = 1'b0;
        o_a_rdata     = r_a_rdata_q;
        o_b_rdata     = r_b_rdata_q;
        o_mem_wren    = 1'b0;
        o_mem_funct3  = 3'b000;
        o_mem_address = '0;
        o_mem_data    = '0;

        if (r_state_q == ST_ACCESS) begin
            o_mem_wren    = w_store_en;
            o_mem_funct3  = r_cmd_funct3_q;
            o_mem_address = r_cmd_addr_q;
            o_mem_data    = r_cmd_wdata_q;
        end

        if (r_state_q == ST_RESP) begin
            o_a_rsp_valid = (r_cmd_id_q == c_PORT_A);
            o_b_rsp_valid = (r_cmd_id_q == c_PORT_B);
        end
    end

    // ------------------------------------------------------------------
    // State registers. last_grant resets to B so A wins the first contest.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state_q      <= ST_IDLE;
            r_last_grant_q <= c_PORT_B;
            r_cmd_we_q     <= 1'b0;
            r_cmd_funct3_q <= 3'b000;
            r_cmd_addr_q   <= '0;
            r_cmd_wdata_q  <= '0;
            r_cmd_id_q     <= c_PORT_A;
            r_a_rdata_q    <= '0;
            r_b_rdata_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_cmd_we_q     <= w_cmd_we_d;
            r_cmd_funct3_q <= w_cmd_funct3_d;
            r_cmd_addr_q   <= w_cmd_addr_d;
            r_cmd_wdata_q  <= w_cmd_wdata_d;
            r_cmd_id_q     <= w_cmd_id_d;
            r_a_rdata_q    <= w_a_rdata_d;
            r_b_rdata_q    <= w_b_rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A byte-array RAM model
//            sits behind the arbiter; a shadow memory and a scoreboard hold
//            the expected responses, which are compared when the DUT pulses
//            rsp_valid.
// Revision : 1.0 - initial release
// Build option honoured: DMEM_ARB_LOAD_EXT_EN
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int   ADDR_W = 8;
    localparam int   DATA_W = 32;
    localparam logic PA     = 1'b0;
    localparam logic PB     = 1'b1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic ram_clr = 1'b1;
    always #5 clk = ~clk;

    logic              a_valid, a_we, b_valid, b_we;
    logic [2:0]        a_funct3, b_funct3;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              o_a_ready, o_b_ready, o_a_rsp_valid, o_b_rsp_valid;
    logic [DATA_W-1:0] o_a_rdata, o_b_rdata;
    logic              o_mem_wren;
    logic [2:0]        o_mem_funct3;
    logic [ADDR_W-1:0] o_mem_address;
    logic [DATA_W-1:0] o_mem_data;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_a_valid     (a_valid),
        .o_a_ready     (o_a_ready),
        .i_a_we        (a_we),
        .i_a_funct3    (a_funct3),
        .i_a_addr      (a_addr),
        .i_a_wdata     (a_wdata),
        .o_a_rsp_valid (o_a_rsp_valid),
        .o_a_rdata     (o_a_rdata),
        .i_b_valid     (b_valid),
        .o_b_ready     (o_b_ready),
        .i_b_we        (b_we),
        .i_b_funct3    (b_funct3),
        .i_b_addr      (b_addr),
        .i_b_wdata     (b_wdata),
        .o_b_rsp_valid (o_b_rsp_valid),
        .o_b_rdata     (o_b_rdata),
        .o_mem_wren    (o_mem_wren),
        .o_mem_funct3  (o_mem_funct3),
        .o_mem_address (o_mem_address),
        .o_mem_data    (o_mem_data),
        .i_mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM model: combinational read, little-endian, addresses wrap at 256.
    // ------------------------------------------------------------------
    logic [7:0] ram    [256];
    logic [7:0] shadow [256];

    always_comb begin
        mem_rdata = {ram[8'(o_mem_address + 8'd3)], ram[8'(o_mem_address + 8'd2)],
                     ram[8'(o_mem_address + 8'd1)], ram[o_mem_address]};
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (o_mem_wren) begin
            ram[o_mem_address] <= o_mem_data[7:0];
            if (o_mem_funct3 != 3'b000) ram[8'(o_mem_address + 8'd1)] <= o_mem_data[15:8];
            if (o_mem_funct3 == 3'b010) begin
                ram[8'(o_mem_address + 8'd2)] <= o_mem_data[23:16];
                ram[8'(o_mem_address + 8'd3)] <= o_mem_data[31:24];
            end
        end
    end

    function automatic logic [31:0] ram_word(input logic [7:0] a);
        return {ram[8'(a + 8'd3)], ram[8'(a + 8'd2)], ram[8'(a + 8'd1)], ram[a]};
    endfunction

    function automatic logic [31:0] sh_word(input logic [7:0] a);
        return {shadow[8'(a + 8'd3)], shadow[8'(a + 8'd2)], shadow[8'(a + 8'd1)], shadow[a]};
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] w);
        logic ext;
        logic [31:0] r;
        ext = 1'b0;
`ifdef DMEM_ARB_LOAD_EXT_EN
        ext = 1'b1;
`endif
        r = w;
        if (ext) begin
            case (f3)
                3'b000:  r = {{24{w[7]}}, w[7:0]};
                3'b001:  r = {{16{w[15]}}, w[15:0]};
                3'b100:  r = {24'd0, w[7:0]};
                3'b101:  r = {16'd0, w[15:0]};
                default: r = w;
            endcase
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    logic       gq[$];     // port actually granted by the DUT, in order
    int         aq[$];     // cycle of each DUT acceptance
    int         cyc = 0;
    logic       acc_pend = 1'b0;
    logic       acc_wren;
    logic [2:0] acc_f3;
    logic [7:0] acc_addr;
    logic [31:0] acc_data;
    logic       m_last = PB;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        logic in_access, ea, eb, we;
        logic [2:0] f3;
        logic [7:0] ad;
        exp_t e;
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        end
        if (!rst_n) begin
            sb.delete();
            acc_pend = 1'b0;
            m_last   = PB;
            last_a   = '0;
            last_b   = '0;
        end else begin
            in_access = acc_pend;
            if (acc_pend) begin
                chk("mem_wren",    32'(o_mem_wren),    32'(acc_wren));
                chk("mem_funct3",  32'(o_mem_funct3),  32'(acc_f3));
                chk("mem_address", 32'(o_mem_address), 32'(acc_addr));
                chk("mem_data",    o_mem_data,         acc_data);
                if (acc_wren) begin
                    shadow[acc_addr] = acc_data[7:0];
                    if (acc_f3 != 3'b000) shadow[8'(acc_addr + 8'd1)] = acc_data[15:8];
                    if (acc_f3 == 3'b010) begin
                        shadow[8'(acc_addr + 8'd2)] = acc_data[23:16];
                        shadow[8'(acc_addr + 8'd3)] = acc_data[31:24];
                    end
                end
                acc_pend = 1'b0;
            end else begin
                chk("idle_mem_wren",    32'(o_mem_wren),    32'd0);
                chk("idle_mem_address", 32'(o_mem_address), 32'd0);
            end

            if (o_a_rsp_valid || o_b_rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'({o_a_rsp_valid, o_b_rsp_valid}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_port", 32'({o_a_rsp_valid, o_b_rsp_valid}),
                        (e.port == PA) ? 32'd2 : 32'd1);
                    chk("rsp_latency", 32'(cyc - e.cyc), 32'd2);
                    if (e.port == PA) begin
                        chk("rsp_rdata_a", o_a_rdata, e.rdata);
                        last_a = e.rdata;
                    end else begin
                        chk("rsp_rdata_b", o_b_rdata, e.rdata);
                        last_b = e.rdata;
                    end
                end
            end else if (sb.size() != 0 && (cyc - sb[0].cyc) > 2) begin
                chk("rsp_missing", 32'(o_a_rsp_valid | o_b_rsp_valid), 32'd1);
                e = sb.pop_front();
            end
            if (!o_a_rsp_valid) chk("hold_rdata_a", o_a_rdata, last_a);
            if (!o_b_rsp_valid) chk("hold_rdata_b", o_b_rdata, last_b);

            // Reference arbitration: accept whenever not in the RAM cycle.
            ea = !in_access && a_valid && (!b_valid || m_last == PB);
            eb = !in_access && b_valid && (!a_valid || m_last == PA);
            chk("a_ready", 32'(o_a_ready), 32'(ea));
            chk("b_ready", 32'(o_b_ready), 32'(eb));
            if ((o_a_ready && a_valid) || (o_b_ready && b_valid)) begin
                gq.push_back(o_b_ready);
                aq.push_back(cyc);
            end
            if (ea || eb) begin
                we = eb ? b_we     : a_we;
                f3 = eb ? b_funct3 : a_funct3;
                ad = eb ? b_addr   : a_addr;
                e.port  = eb;
                e.cyc   = cyc;
                e.rdata = we ? 32'd0 : exp_load(f3, sh_word(ad));
                sb.push_back(e);
                acc_pend = 1'b1;
                acc_wren = we && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
                acc_f3   = f3;
                acc_addr = ad;
                acc_data = eb ? b_wdata : a_wdata;
                m_last   = eb;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request driver: each port presents the head of its queue until taken.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
    } req_t;

    req_t qa[$];
    req_t qb[$];

    task automatic req(input logic port, input logic we, input logic [2:0] f3,
                       input logic [7:0] addr, input logic [31:0] wd);
        req_t r;
        r.we = we; r.f3 = f3; r.addr = addr; r.wd = wd;
        if (port == PA) qa.push_back(r);
        else            qb.push_back(r);
    endtask

    task automatic run();
        int   n;
        logic ta, tb;
        req_t d;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
            a_valid = (qa.size() != 0);
            if (a_valid) begin
                a_we = qa[0].we; a_funct3 = qa[0].f3; a_addr = qa[0].addr; a_wdata = qa[0].wd;
            end
            b_valid = (qb.size() != 0);
            if (b_valid) begin
                b_we = qb[0].we; b_funct3 = qb[0].f3; b_addr = qb[0].addr; b_wdata = qb[0].wd;
            end
            @(negedge clk);
            ta = a_valid && o_a_ready;
            tb = b_valid && o_b_ready;
            @(posedge clk);
            #1;
            if (ta) d = qa.pop_front();
            if (tb) d = qb.pop_front();
            n++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (qa.size() != 0 || qb.size() != 0) begin
            chk("drive_timeout", 32'(qa.size() + qb.size()), 32'd0);
            qa.delete();
            qb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        a_valid = 1'b0; a_we = 1'b0; a_funct3 = 3'b000; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_funct3 = 3'b000; b_addr = '0; b_wdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready",     32'(o_a_ready),     32'd0);
        chk("rst_b_ready",     32'(o_b_ready),     32'd0);
        chk("rst_a_rsp_valid", 32'(o_a_rsp_valid), 32'd0);
        chk("rst_b_rsp_valid", 32'(o_b_rsp_valid), 32'd0);
        chk("rst_a_rdata",     o_a_rdata,          32'd0);
        chk("rst_b_rdata",     o_b_rdata,          32'd0);
        chk("rst_mem_wren",    32'(o_mem_wren),    32'd0);
        chk("rst_mem_funct3",  32'(o_mem_funct3),  32'd0);
        chk("rst_mem_address", 32'(o_mem_address), 32'd0);
        chk("rst_mem_data",    o_mem_data,         32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ram_clr = 1'b0;
        @(posedge clk);
        #1;

        // A store word, then load it back; first contest goes to A
        gq.delete();
        req(PA, 1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
        run();
        chk("first_grant_a", (gq.size() > 0) ? 32'(gq[0]) : 32'd1, 32'(PA));
        chk("ram_word_10", ram_word(8'h10), 32'hDEADBEEF);
        req(PA, 1'b0, 3'b010, 8'h10, 32'd0);
        run();
        chk("a_rdata_load_10", o_a_rdata, 32'hDEADBEEF);

        // Both ports continuously valid: strict alternation, B first (A won last)
        gq.delete();
        aq.delete();
        for (int i = 0; i < 4; i++) begin
            req(PA, 1'b0, 3'b010, 8'(4 * i), 32'd0);
            req(PB, 1'b0, 3'b010, 8'(8'h11 + i), 32'd0);
        end
        run();
        chk("rr_grant_count", 32'(gq.size()), 32'd8);
        for (int i = 0; i < gq.size() && i < 8; i++) begin
            chk("rr_grant_order", 32'(gq[i]), (i % 2 == 0) ? 32'(PB) : 32'(PA));
        end
        for (int i = 1; i < aq.size() && i < 8; i++) begin
            chk("rr_accept_spacing", 32'(aq[i] - aq[i-1]), 32'd2);
        end

        // B store with unsupported size: acknowledged, memory untouched
        req(PB, 1'b1, 3'b011, 8'h20, 32'h12345678);
        run();
        chk("nop_store_ram_20", ram_word(8'h20), 32'd0);
        chk("nop_store_b_rdata", o_b_rdata, 32'd0);
        req(PA, 1'b0, 3'b010, 8'h20, 32'd0);
        run();

        // Load extension cases
        req(PA, 1'b1, 3'b010, 8'h40, 32'h00000080);
        req(PA, 1'b0, 3'b000, 8'h40, 32'd0);
        req(PA, 1'b0, 3'b100, 8'h40, 32'd0);
        req(PA, 1'b1, 3'b010, 8'h44, 32'h00008123);
        req(PA, 1'b0, 3'b001, 8'h44, 32'd0);
        req(PB, 1'b0, 3'b101, 8'h44, 32'd0);
        run();

        // Top-of-memory address and misaligned word spanning the wrap
        req(PA, 1'b1, 3'b000, 8'hFF, 32'h000000A5);
        req(PA, 1'b0, 3'b100, 8'hFF, 32'd0);
        req(PB, 1'b0, 3'b010, 8'hFE, 32'd0);
        run();
        chk("ram_byte_ff", 32'(ram[8'hFF]), 32'h000000A5);

        // Reset asserted during the ACCESS cycle of an A store
        a_we = 1'b1; a_funct3 = 3'b010; a_addr = 8'h30; a_wdata = 32'hCAFEF00D;
        a_valid = 1'b1;
        @(negedge clk);
        chk("rst_test_accept", 32'(o_a_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("rst_test_access_wren", 32'(o_mem_wren), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wren",    32'(o_mem_wren),    32'd0);
        chk("midrst_address", 32'(o_mem_address), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp_a", 32'(o_a_rsp_valid), 32'd0);
        end
        chk("midrst_ram_30", ram_word(8'h30), 32'd0);
        gq.delete();
        req(PA, 1'b0, 3'b010, 8'h30, 32'd0);
        req(PB, 1'b0, 3'b010, 8'h10, 32'd0);
        run();
        chk("midrst_first_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'd1, 32'(PA));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
